ps2_key_matrix: RTL and testbench
=================================

// Module: ps2_key_matrix
// PURPOSE
//  Upstream stage of the LM80C keyboard path: receives a PS/2 scan-code set 2 stream and
//  builds the 8x8 active-low key matrix KM[row][col] that the PSG port-A/port-B scan reads.
//  It replaces host-side matrix generation; KM is a level image of currently held keys.
//  Also flags framing errors and exposes an F12 reset request for the top level.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal sys_clock samples before filtered ps2_clk may change
//  TIMEOUT_CYCLES  100000  sys_clock cycles without a ps2_clk fall mid-frame -> abort frame
// PORTS
//  sys_clock   in   1      system clock
//  RESET       in   1      synchronous, active-high reset
//  ps2_clk     in   1      raw PS/2 clock (async)
//  ps2_data    in   1      raw PS/2 data (async)
//  KM          out  8x8    output [7:0] KM[7:0]; bit KM[r][c]=0 -> key (r,c) held
//  byte_valid  out  1      one-cycle pulse: rx_byte holds a good frame
//  rx_byte     out  8      last correctly received byte
//  frame_err   out  1      one-cycle pulse: parity/stop error or timeout
//  reset_req   out  1      level: high while F12 (0x07) held
// BEHAVIOUR
//  Reset (RESET=1 at sys_clock edge): all KM rows 8'hFF, FSM IDLE, ext/brk flags 0,
//   skip counter 0, byte_valid=0, frame_err=0, rx_byte=0, reset_req=0, filter=1, timeout=0.
//   RESET mid-frame discards the partial byte; no pulse is produced.
//  Input: 2-FF synchroniser on both lines; filtered clk toggles only after FILTER_LEN equal
//   samples. Data sampled on filtered clk falling edge (fall = one-cycle strobe).
//  RX FSM (advances on fall strobes only):
//   IDLE  : data=0 -> DATA, bitcnt=0; data=1 -> stay IDLE (spurious, no error)
//   DATA  : shift in LSB first; after 8th bit -> PARITY
//   PARITY: capture; -> STOP
//   STOP  : if data=1 and (8 data bits + parity) odd -> byte_valid pulse, rx_byte updated;
//           else frame_err pulse; always -> IDLE
//   Timeout: counter clears on every fall; in non-IDLE, reaching TIMEOUT_CYCLES -> IDLE + frame_err.
//   byte_valid asserts the cycle after the STOP fall strobe.
//  Decoder (acts on byte_valid):
//   0xE0 -> ext=1; 0xF0 -> brk=1; 0xE1 -> skip=7 (pause sequence ignored, skip decrements per byte)
//   0xAA,0xFA,0xEE,0xFE,0x00 ignored, flags unchanged; 0xFF (overrun) -> all KM rows 8'hFF, flags 0
//   other code: lookup {ext,code}; on hit KM[row][col] <= brk (press=0, release=1);
//    miss -> no change; ext,brk cleared after every non-prefix byte (hit or miss)
//   KM change visible 1 cycle after byte_valid (2 cycles after STOP fall strobe).
//   code 0x07 non-ext: reset_req <= ~brk (not in matrix).
//   Both shifts (0x12, 0x59) map to (6,0): releasing either releases the key (accepted).
//  Keymap (fixed function in file; unlisted codes miss). Test-anchored entries:
//   0x1C A->(1,0)  0x32 B->(1,1)  0x16 1->(2,1)  0x5A Enter->(0,7)  0x29 Space->(0,6)
//   0x12/0x59 Shift->(6,0)  0x14 Ctrl->(6,1)  E0+0x75 Up->(7,2)  E0+0x72 Down->(7,3)
//   Non-ext 0x75/0x72 (keypad 8/2) miss -> no change.
//  Simultaneous: decoder and overrun clear never coincide (one byte per byte_valid);
//   multiple held keys clear independent bits; repeated make codes are idempotent.
// TESTING
//  Send 0x1C frame (odd parity ok) -> byte_valid pulse, rx_byte=0x1C, KM[1]=8'hFE; then F0,1C -> KM[1]=8'hFF.
//  Send E0,75 -> KM[7]=8'hFB; send 75 alone -> KM unchanged; E0,F0,75 -> KM[7]=8'hFF.
//  Send 0x1C with bad parity -> frame_err pulse, no byte_valid, KM[1] stays 8'hFF.
//  Send start+3 bits then stall TIMEOUT_CYCLES -> frame_err, FSM IDLE; next 0x5A frame -> KM[0]=8'h7F.
//  Hold 1C,32,12 then send FF -> all KM rows 8'hFF; send 07 -> reset_req=1; F0,07 -> reset_req=0.
//  Glitch ps2_clk low for FILTER_LEN-1 cycles in IDLE -> no state change; RESET mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 receiver and scan-code decoder that maintains an 8x8 active-low
// key matrix (level image of held keys), plus an F12 reset request.
module ps2_key_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sys_clock,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] KM [7:0],
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       reset_req
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [1:0]  clk_sync, dat_sync;
  logic        s_clk, s_dat;
  logic        filt_clk;
  logic [FW-1:0] filt_cnt;
  logic        fall;
  logic [TW-1:0] to_cnt;
  logic        to_hit;

  rx_state_t   state, state_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        par, par_n;
  logic        bv_n, fe_n;
  logic [7:0]  rxb_n;

  logic        ext, brk;
  logic [2:0]  skip;
  logic [6:0]  km_ent;
  logic        km_hit;
  logic [2:0]  km_row, km_col;

  assign s_clk = clk_sync[1];
  assign s_dat = dat_sync[1];

  // Two-flop synchronisers; lines idle high so reset to 1.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Glitch filter: filtered clock follows only after FILTER_LEN differing samples.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (s_clk == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_clk <= s_clk;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Fall strobe is the cycle the filtered clock is about to drop.
  assign fall   = filt_clk && !s_clk && (filt_cnt == FW'(FILTER_LEN - 1));
  assign to_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Mid-frame watchdog: restarts on every clock fall, idle while waiting for a start bit.
  always_ff @(posedge sys_clock) begin
    if (RESET || fall || state == IDLE) to_cnt <= '0;
    else                                to_cnt <= to_cnt + 1'b1;
  end

  // Receiver state and registered pulse outputs.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
      rx_byte    <= rxb_n;
    end
  end

  // Receiver next-state: frame bits are consumed only on fall strobes.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    bv_n     = 1'b0;
    fe_n     = 1'b0;
    rxb_n    = rx_byte;
    if (to_hit) begin
      state_n = IDLE;
      fe_n    = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: if (!s_dat) begin
          state_n  = DATA;
          bitcnt_n = '0;
        end
        DATA: begin
          shreg_n  = {s_dat, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = s_dat;
          state_n = STOP;
        end
        STOP: begin
          if (s_dat && (^{par, shreg})) begin
            bv_n  = 1'b1;
            rxb_n = shreg;
          end else begin
            fe_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Scan-code map: {ext, code} -> {hit, row, col}.
  function automatic logic [6:0] keymap(input logic [8:0] key);
    case (key)
      9'h01C: keymap = {1'b1, 3'd1, 3'd0};  // A
      9'h032: keymap = {1'b1, 3'd1, 3'd1};  // B
      9'h021: keymap = {1'b1, 3'd1, 3'd2};  // C
      9'h023: keymap = {1'b1, 3'd1, 3'd3};  // D
      9'h024: keymap = {1'b1, 3'd1, 3'd4};  // E
      9'h02B: keymap = {1'b1, 3'd1, 3'd5};  // F
      9'h034: keymap = {1'b1, 3'd1, 3'd6};  // G
      9'h033: keymap = {1'b1, 3'd1, 3'd7};  // H
      9'h016: keymap = {1'b1, 3'd2, 3'd1};  // 1
      9'h01E: keymap = {1'b1, 3'd2, 3'd2};  // 2
      9'h026: keymap = {1'b1, 3'd2, 3'd3};  // 3
      9'h025: keymap = {1'b1, 3'd2, 3'd4};  // 4
      9'h066: keymap = {1'b1, 3'd0, 3'd0};  // Backspace
      9'h076: keymap = {1'b1, 3'd0, 3'd1};  // Esc
      9'h00D: keymap = {1'b1, 3'd0, 3'd2};  // Tab
      9'h029: keymap = {1'b1, 3'd0, 3'd6};  // Space
      9'h05A: keymap = {1'b1, 3'd0, 3'd7};  // Enter
      9'h012: keymap = {1'b1, 3'd6, 3'd0};  // Left shift
      9'h059: keymap = {1'b1, 3'd6, 3'd0};  // Right shift shares the key
      9'h014: keymap = {1'b1, 3'd6, 3'd1};  // Ctrl
      9'h011: keymap = {1'b1, 3'd6, 3'd2};  // Alt
      9'h114: keymap = {1'b1, 3'd6, 3'd1};  // Right ctrl
      9'h111: keymap = {1'b1, 3'd6, 3'd2};  // Right alt
      9'h16B: keymap = {1'b1, 3'd7, 3'd0};  // Left
      9'h174: keymap = {1'b1, 3'd7, 3'd1};  // Right
      9'h175: keymap = {1'b1, 3'd7, 3'd2};  // Up
      9'h172: keymap = {1'b1, 3'd7, 3'd3};  // Down
      default: keymap = 7'd0;
    endcase
  endfunction

  assign km_ent = keymap({ext, rx_byte});
  assign km_hit = km_ent[6];
  assign km_row = km_ent[5:3];
  assign km_col = km_ent[2:0];

  // Decoder: prefix flags, pause skipping, overrun clear and matrix updates.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip      <= '0;
      reset_req <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else begin
        case (rx_byte)
          8'hE0: ext  <= 1'b1;
          8'hF0: brk  <= 1'b1;
          8'hE1: skip <= 3'd7;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00: ;
          8'hFF: begin
            for (int r = 0; r < 8; r++) KM[r] <= 8'hFF;
            ext <= 1'b0;
            brk <= 1'b0;
          end
          default: begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (!ext && rx_byte == 8'h07) reset_req <= ~brk;
            else if (km_hit)              KM[km_row][km_col] <= brk;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: PS/2 frames are bit-banged, expected
// receiver events go to a scoreboard queue, matrix state is checked against constants.
module tb_ps2_key_matrix;

  localparam int FLEN = 8;
  localparam int TO   = 600;
  localparam int H    = 20;   // half PS/2 clock period in sys_clock cycles

  logic       sys_clock = 1'b0;
  logic       RESET = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] KM [7:0];
  logic       byte_valid, frame_err, reset_req;
  logic [7:0] rx_byte;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;
  exp_t sbq[$];
  exp_t sb_e;

  ps2_key_matrix #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clock (sys_clock),
    .RESET     (RESET),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .KM        (KM),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .reset_req (reset_req)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(H);
    ps2_clk = 1'b0;
    cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good);
    sbq.push_back('{err: !good, b: b});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good ? ~^b : ^b);
    send_bit(1'b1);
    cyc(H);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    for (int r = 0; r < 8; r++) chk($sformatf("%s_km%0d", pfx, r), KM[r], 8'hFF);
    chk({pfx, "_bv"}, byte_valid, 1'b0);
    chk({pfx, "_fe"}, frame_err, 1'b0);
    chk({pfx, "_rxb"}, rx_byte, 8'h00);
    chk({pfx, "_rreq"}, reset_req, 1'b0);
  endtask

  // Scoreboard: every receiver pulse must match the oldest expected event.
  always @(negedge sys_clock) begin
    if (!RESET && (byte_valid || frame_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_unexpected observed=bv%0b_fe%0b_%0h expected=none", byte_valid, frame_err, rx_byte);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_event", {frame_err, byte_valid, sb_e.err ? 8'h00 : rx_byte},
            {sb_e.err, ~sb_e.err, sb_e.err ? 8'h00 : sb_e.b});
      end
    end
  end

  initial begin
    cyc(4);
    chk_reset_vals("rst");
    RESET = 1'b0;
    cyc(10);

    // Press and release A
    send(8'h1C);
    chk("a_press", KM[1], 8'hFE);
    send(8'hF0); send(8'h1C);
    chk("a_release", KM[1], 8'hFF);

    // Extended Up, non-extended 0x75 misses, extended release
    send(8'hE0); send(8'h75);
    chk("up_press", KM[7], 8'hFB);
    send(8'h75);
    chk("kp8_miss_km7", KM[7], 8'hFB);
    chk("kp8_miss_km1", KM[1], 8'hFF);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_release", KM[7], 8'hFF);

    // Bad parity frame
    send_frame(8'h1C, 1'b0);
    chk("badpar_km1", KM[1], 8'hFF);
    chk("badpar_rxb", rx_byte, 8'h75);

    // Stall mid-frame after start + 3 bits
    sbq.push_back('{err: 1'b1, b: 8'h00});
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(TO + 100);
    send(8'h5A);
    chk("enter_after_to", KM[0], 8'h7F);
    send(8'hF0); send(8'h5A);
    chk("enter_release", KM[0], 8'hFF);

    // Multiple held keys, then overrun clear
    send(8'h1C); send(8'h32); send(8'h12);
    send(8'h1C);
    chk("multi_km1", KM[1], 8'hFC);
    chk("multi_km6", KM[6], 8'hFE);
    send(8'hFF);
    chk("ovr_km1", KM[1], 8'hFF);
    chk("ovr_km6", KM[6], 8'hFF);

    // F12 reset request
    send(8'h07);
    chk("f12_press", reset_req, 1'b1);
    chk("f12_km6", KM[6], 8'hFF);
    send(8'hF0); send(8'h07);
    chk("f12_release", reset_req, 1'b0);

    // Pause sequence is swallowed, next byte decodes normally
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_km6", KM[6], 8'hFF);
    send(8'h29);
    chk("space_press", KM[0], 8'hBF);
    send(8'hAA);
    chk("ignored_aa", KM[0], 8'hBF);
    send(8'hF0); send(8'h29);
    chk("space_release", KM[0], 8'hFF);

    // Press left shift, release with right shift code
    send(8'h12);
    chk("shift_press", KM[6], 8'hFE);
    send(8'hF0); send(8'h59);
    chk("shift_release", KM[6], 8'hFF);

    // Sub-threshold clock glitch in idle with data low
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    cyc(FLEN - 1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(TO + 100);
    send(8'h16);
    chk("glitch_then_1", KM[2], 8'hFD);

    // Reset in the middle of a frame with keys and F12 held
    send(8'h07);
    chk("pre_rst_rreq", reset_req, 1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cyc(H / 2);
    RESET = 1'b1;
    cyc(2);
    chk_reset_vals("midrst");
    RESET = 1'b0;
    ps2_data = 1'b1;
    cyc(TO + 100);
    send(8'h1C);
    chk("post_rst_a", KM[1], 8'hFE);

    cyc(50);
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
